video_axis_sink: RTL and testbench

VIDEO_AXIS_SINK -- requirements
Module: video_axis_sink

---
 rtl/video_pkg.sv | 18 +
 rtl/video_sink_sum.sv | 41 ++++
 rtl/video_axis_sink.sv | 150 +++++++++++++++
 tb/tb_video_axis_sink.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and widths for the video AXI-Stream sink.
package video_pkg;

    localparam int XW    = 13;
    localparam int YW    = 13;
    localparam int STATW = 16;
    localparam int SUMW  = 32;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        ACTIVE   = 1'b1
    } state_t;

    function automatic logic [STATW-1:0] sat_inc(input logic [STATW-1:0] v);
        return (&v) ? v : v + STATW'(1);
    endfunction

endpackage

// File: rtl/video_sink_sum.sv
// Per-frame tdata checksum; only compiled when VIDEO_SINK_CHECKSUM_EN is defined.
`ifdef VIDEO_SINK_CHECKSUM_EN
module video_sink_sum
    import video_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DATAW-1:0] data,
    input  logic             start,
    input  logic             add,
    input  logic             done,
    input  logic             discard,
    output logic [SUMW-1:0]  frame_sum
);

    logic [SUMW-1:0] acc;
    logic [SUMW-1:0] beat;

    assign beat = SUMW'(data);

    // The final beat is folded in directly so frame_sum is valid alongside frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            frame_sum <= '0;
        end else if (start) begin
            acc <= beat;
        end else if (done) begin
            frame_sum <= acc + beat;
            acc       <= '0;
        end else if (discard) begin
            acc <= '0;
        end else if (add) begin
            acc <= acc + beat;
        end
    end

endmodule
`endif

// File: rtl/video_axis_sink.sv
// AXI-Stream video sink: frame/line framing checker with sticky errors and statistics.
// Optional checksum accumulator enabled by defining VIDEO_SINK_CHECKSUM_EN.
module video_axis_sink
    import video_pkg::*;
#(
    parameter int DATAW = 32,
    parameter int SCRW  = 1280,
    parameter int SCRH  = 720
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               clr_err,
    input  logic [DATAW-1:0]   s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tuser,
    input  logic               s_axis_tlast,
    input  logic [DATAW/8-1:0] s_axis_tkeep,
    output logic               frame_done,
    output logic [STATW-1:0]   frame_cnt,
    output logic               locked,
    output logic               sof_err,
    output logic               eol_early_err,
    output logic               eol_late_err,
    output logic [STATW-1:0]   err_cnt,
    output logic [SUMW-1:0]    frame_sum
);

    // NOTE: assertion stays asynchronous; only the release is retimed to clk.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= '0;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    state_t          state, state_nxt;
    logic [XW-1:0]   x, x_nxt;
    logic [YW-1:0]   y, y_nxt;
    logic            accept, x_last, y_last, frame_clean;
    logic            start_ev, done_ev, sof_ev, early_ev, late_ev, err_ev;

    assign accept = s_axis_tvalid & s_axis_tready;
    assign x_last = (x == XW'(SCRW - 1));
    assign y_last = (y == YW'(SCRH - 1));
    assign err_ev = sof_ev | early_ev | late_ev;

    // NOTE: every output gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        start_ev  = 1'b0;
        done_ev   = 1'b0;
        sof_ev    = 1'b0;
        early_ev  = 1'b0;
        late_ev   = 1'b0;
        if (accept) begin
            case (state)
                WAIT_SOF: if (s_axis_tuser) begin
                    start_ev  = 1'b1;
                    x_nxt     = XW'(1);
                    y_nxt     = '0;
                    state_nxt = ACTIVE;
                end
                ACTIVE: if (s_axis_tuser) begin
                    sof_ev   = 1'b1;
                    start_ev = 1'b1;
                    x_nxt    = XW'(1);
                    y_nxt    = '0;
                end else if (x_last && s_axis_tlast) begin
                    x_nxt = '0;
                    if (y_last) begin
                        done_ev   = 1'b1;
                        y_nxt     = '0;
                        state_nxt = WAIT_SOF;
                    end else begin
                        y_nxt = y + YW'(1);
                    end
                end else if (x_last || s_axis_tlast) begin
                    early_ev  = s_axis_tlast;
                    late_ev   = x_last;
                    x_nxt     = '0;
                    y_nxt     = '0;
                    state_nxt = WAIT_SOF;
                end else begin
                    x_nxt = x + XW'(1);
                end
                default: state_nxt = WAIT_SOF;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_SOF;
            x             <= '0;
            y             <= '0;
            s_axis_tready <= 1'b0;
            frame_done    <= 1'b0;
            frame_cnt     <= '0;
            frame_clean   <= 1'b0;
            locked        <= 1'b0;
            sof_err       <= 1'b0;
            eol_early_err <= 1'b0;
            eol_late_err  <= 1'b0;
            err_cnt       <= '0;
        end else begin
            state         <= state_nxt;
            x             <= x_nxt;
            y             <= y_nxt;
            s_axis_tready <= en;
            frame_done    <= done_ev;
            frame_cnt     <= frame_cnt + STATW'(done_ev);
            if (start_ev) frame_clean <= ~sof_ev;
            if (err_ev)                      locked <= 1'b0;
            else if (done_ev && frame_clean) locked <= 1'b1;
            // An error coinciding with clr_err wins over the clear.
            sof_err       <= (sof_err & ~clr_err) | sof_ev;
            eol_early_err <= (eol_early_err & ~clr_err) | early_ev;
            eol_late_err  <= (eol_late_err & ~clr_err) | late_ev;
            if (clr_err)     err_cnt <= err_ev ? STATW'(1) : '0;
            else if (err_ev) err_cnt <= sat_inc(err_cnt);
        end
    end

    logic unused_inputs;

`ifdef VIDEO_SINK_CHECKSUM_EN
    video_sink_sum #(.DATAW(DATAW)) u_sum (
        .clk       (clk),
        .rst_n     (rst_n),
        .data      (s_axis_tdata),
        .start     (start_ev),
        .add       (accept && state == ACTIVE),
        .done      (done_ev),
        .discard   (early_ev | late_ev),
        .frame_sum (frame_sum)
    );
    assign unused_inputs = ^s_axis_tkeep;
`else
    assign frame_sum     = '0;
    assign unused_inputs = ^{s_axis_tkeep, s_axis_tdata};
`endif

endmodule

// File: tb/tb_video_axis_sink.sv
// Self-checking bench for video_axis_sink (8x4 frames) against a pixel-index reference model.
module tb_video_axis_sink;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        clr_err = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tuser = 1'b0;
    logic        tlast = 1'b0;
    logic [3:0]  tkeep = '1;
    logic        s_axis_tready, frame_done, locked, sof_err, eol_early_err, eol_late_err;
    logic [15:0] frame_cnt, err_cnt;
    logic [31:0] frame_sum;

    video_axis_sink #(.DATAW(32), .SCRW(W), .SCRH(H)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .clr_err       (clr_err),
        .s_axis_tdata  (tdata),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tuser  (tuser),
        .s_axis_tlast  (tlast),
        .s_axis_tkeep  (tkeep),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .locked        (locked),
        .sof_err       (sof_err),
        .eol_early_err (eol_early_err),
        .eol_late_err  (eol_late_err),
        .err_cnt       (err_cnt),
        .frame_sum     (frame_sum)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: frame tracked as a linear pixel index.
    bit          m_tready, m_in_frame, m_clean;
    int          m_pix;
    logic [31:0] m_sum;
    bit          e_done, e_locked, e_sof, e_early, e_late;
    logic [15:0] e_frame_cnt, e_err_cnt;
    logic [31:0] e_frame_sum;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tready = 0; m_in_frame = 0; m_clean = 0; m_pix = 0; m_sum = '0;
        e_done = 0; e_locked = 0; e_sof = 0; e_early = 0; e_late = 0;
        e_frame_cnt = '0; e_err_cnt = '0; e_frame_sum = '0;
    endtask

    task automatic model_beat(input bit acc, input bit u, input bit l, input logic [31:0] d,
                              input bit clr);
        bit err = 0;
        e_done = 0;
        if (clr) begin
            e_sof = 0; e_early = 0; e_late = 0; e_err_cnt = '0;
        end
        if (acc) begin
            if (!m_in_frame) begin
                if (u) begin
                    m_in_frame = 1; m_pix = 1; m_sum = d; m_clean = 1;
                end
            end else if (u) begin
                e_sof = 1; err = 1; m_pix = 1; m_sum = d; m_clean = 0;
            end else if (l != (m_pix % W == W - 1)) begin
                if (l) e_early = 1;
                else   e_late = 1;
                err = 1; m_in_frame = 0;
            end else begin
                m_sum += d;
                m_pix++;
                if (m_pix == W * H) begin
                    e_done = 1; m_in_frame = 0; e_frame_cnt++; e_frame_sum = m_sum;
                    if (m_clean) e_locked = 1;
                end
            end
        end
        if (err) begin
            e_locked = 0;
            if (e_err_cnt != 16'hFFFF) e_err_cnt++;
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_sum;
`ifdef VIDEO_SINK_CHECKSUM_EN
        exp_sum = e_frame_sum;
`else
        exp_sum = '0;
`endif
        check("tready", s_axis_tready, m_tready);
        check("frame_done", frame_done, e_done);
        check("frame_cnt", frame_cnt, e_frame_cnt);
        check("locked", locked, e_locked);
        check("sof_err", sof_err, e_sof);
        check("eol_early_err", eol_early_err, e_early);
        check("eol_late_err", eol_late_err, e_late);
        check("err_cnt", err_cnt, e_err_cnt);
        check("frame_sum", frame_sum, exp_sum);
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic step(input bit v, input bit u, input bit l, input logic [31:0] d,
                        input bit e, input bit c, output bit acc);
        tvalid = v; tuser = u; tlast = l; tdata = d; en = e; clr_err = c;
        tkeep = 4'($urandom);
        acc = v & m_tready;
        @(posedge clk);
        #1;
        model_beat(acc, u, l, d, c);
        m_tready = e;
        check_all();
    endtask

    task automatic send_beat(input bit u, input bit l, input logic [31:0] d, input bit rnd,
                             input bit c);
        bit acc = 0;
        int tries = 0;
        while (!acc && tries < 200) begin
            step(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, u, l, d,
                 rnd ? ($urandom_range(0, 2) != 0) : 1'b1, c, acc);
            tries++;
        end
        check("beat_accept_timeout", acc, 1);
    endtask

    task automatic send_frame(input int n, input bit rnd, input bit idx_data);
        for (int p = 0; p < n; p++)
            send_beat(p == 0, p % W == W - 1, idx_data ? 32'(p) : $urandom, rnd, 0);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(0, 0, 0, $urandom, 1, 0, acc);
    endtask

    task automatic reset_dut();
        #2 rst = 1'b0;
        #1;
        check("rst_tready", s_axis_tready, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_locked", locked, 0);
        check("rst_sof_err", sof_err, 0);
        check("rst_eol_early_err", eol_early_err, 0);
        check("rst_eol_late_err", eol_late_err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_frame_sum", frame_sum, 0);
        model_reset();
        tvalid = 0; tuser = 0; tlast = 0; en = 1; clr_err = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1 m_tready = 1;
    endtask

    initial begin
        logic [31:0] exp_496;
        model_reset();

        // Case 1: clean frame
        reset_dut();
        send_frame(W * H, 0, 0);
        idle(2);
        check("c1_frame_cnt", frame_cnt, 1);
        check("c1_locked", locked, 1);
        check("c1_flags", {sof_err, eol_early_err, eol_late_err}, 0);

        // Case 2: early EOL at line 1 beat 5, rest of that frame discarded, then clean frame
        reset_dut();
        send_frame(W + 5, 0, 0);
        send_beat(0, 1, $urandom, 0, 0);
        check("c2_early", eol_early_err, 1);
        check("c2_err_cnt", err_cnt, 1);
        check("c2_locked", locked, 0);
        for (int p = W + 6; p < W * H; p++) send_beat(0, p % W == W - 1, $urandom, 0, 0);
        send_frame(W * H, 0, 0);
        idle(1);
        check("c2_frame_cnt", frame_cnt, 1);

        // Case 3: late EOL, then mid-frame SOF at line 2 beat 3
        reset_dut();
        send_frame(W - 1, 0, 0);
        send_beat(0, 0, $urandom, 0, 0);
        check("c3_late", eol_late_err, 1);
        send_frame(W * H, 0, 0);
        send_frame(2 * W + 3, 0, 0);
        send_frame(W * H, 0, 0);
        idle(1);
        check("c3_sof", sof_err, 1);
        check("c3_frame_cnt", frame_cnt, 2);
        check("c3_err_cnt", err_cnt, 2);

        // Case 4: random backpressure, then clr_err coinciding with an early tlast
        reset_dut();
        send_frame(W * H, 1, 0);
        idle(2);
        check("c4_frame_cnt", frame_cnt, 1);
        check("c4_locked", locked, 1);
        check("c4_flags", {sof_err, eol_early_err, eol_late_err}, 0);
        send_frame(W - 1, 0, 0);
        send_beat(0, 0, $urandom, 0, 0);
        send_frame(3, 0, 0);
        send_beat(0, 1, $urandom, 0, 1);
        check("c4_clr_early", eol_early_err, 1);
        check("c4_clr_late", eol_late_err, 0);
        check("c4_clr_err_cnt", err_cnt, 1);

        // Case 5: checksum of beat indices
        reset_dut();
        send_frame(W * H, 0, 1);
        idle(2);
`ifdef VIDEO_SINK_CHECKSUM_EN
        exp_496 = 32'd496;
`else
        exp_496 = 32'd0;
`endif
        check("c5_frame_sum", frame_sum, exp_496);

        // Case 6: reset mid-frame, leftover beats ignored until next tuser
        reset_dut();
        send_frame(12, 0, 0);
        reset_dut();
        for (int p = 12; p < W * H; p++) send_beat(0, p % W == W - 1, $urandom, 0, 0);
        check("c6_no_frame", frame_cnt, 0);
        send_frame(W * H, 0, 0);
        idle(1);
        check("c6_frame_cnt", frame_cnt, 1);

        // Random soak: mostly well-formed traffic with occasional framing faults and clears
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            bit want_last, u, l;
            want_last = m_in_frame && (m_pix % W == W - 1);
            u = m_in_frame ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 1) == 1);
            l = ($urandom_range(0, 24) == 0) ? !want_last : want_last;
            send_beat(u, l, $urandom, 1, $urandom_range(0, 29) == 0);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
